// File: rtl/acl2_pkg.sv
// Shared constants, state encoding and transaction byte table for the PmodACL2 sequencer.
package acl2_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] REG_XDATA_L    = 8'h0E;
    localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

    localparam int unsigned WRITE_BYTES = 3;
    localparam int unsigned READ_BYTES  = 8;

    localparam logic [1:0] TXN_FILTER = 2'd0;
    localparam logic [1:0] TXN_POWER  = 2'd1;
    localparam logic [1:0] TXN_READ   = 2'd2;

    typedef enum logic [3:0] {
        StStartup, StLoad, StIssue, StArm, StWait, StNext, StGap, StIdle, StError
    } state_e;

    function automatic logic [7:0] txn_byte(input logic [1:0] txn, input logic [2:0] bi,
                                            input logic [7:0] filter_val,
                                            input logic [7:0] power_val);
        logic [7:0] b;
        b = 8'h00;
        if (txn == TXN_READ) begin
            if (bi == 3'd0)      b = CMD_READ;
            else if (bi == 3'd1) b = REG_XDATA_L;
        end else begin
            if (bi == 3'd0)      b = CMD_WRITE;
            else if (bi == 3'd1) b = (txn == TXN_FILTER) ? REG_FILTER_CTL : REG_POWER_CTL;
            else                 b = (txn == TXN_FILTER) ? filter_val : power_val;
        end
        return b;
    endfunction

    function automatic logic [2:0] last_bi(input logic [1:0] txn);
        return (txn == TXN_READ) ? 3'(READ_BYTES - 1) : 3'(WRITE_BYTES - 1);
    endfunction

endpackage

// File: rtl/acl2_sample_timer.sv
// Free-running sample period counter; held at zero until run goes high, then ticks every period.
module acl2_sample_timer #(
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    logic [23:0] count_q;

    assign tick = run && (count_q == 24'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (!run || tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 24'd1;
        end
    end

endmodule

// File: rtl/acl2_sample_sequencer.sv
// Configures the ADXL362 through a byte-level SPI master, then runs periodic XYZ burst reads.
module acl2_sample_sequencer
    import acl2_pkg::*;
#(
    parameter int unsigned STARTUP_DELAY  = 100,
    parameter int unsigned SAMPLE_PERIOD  = 1000,
    parameter logic [7:0]  FILTER_CTL_VAL = 8'h13,
    parameter logic [7:0]  POWER_CTL_VAL  = 8'h02,
    parameter int unsigned ACK_TIMEOUT    = 16,
    parameter int unsigned BYTE_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  spi_tx_data,
    output logic        spi_start,
    output logic        spi_cs_n,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_active,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
    output logic        sample_valid,
    output logic        config_done,
    output logic        overrun,
    output logic        error
);

    localparam int unsigned CntMax0 = (STARTUP_DELAY > ACK_TIMEOUT) ? STARTUP_DELAY : ACK_TIMEOUT;
    localparam int unsigned CntMax  = (CntMax0 > BYTE_TIMEOUT) ? CntMax0 : BYTE_TIMEOUT;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      txn_q, txn_d;
    logic [2:0]      bi_q, bi_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [7:0]      shadow_q [6];
    logic [7:0]      shadow_d [6];
    logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic            sample_valid_q, sample_valid_d;
    logic            config_done_q, config_done_d;
    logic            overrun_q, overrun_d;
    logic            error_q, error_d;
    logic            tick;

    acl2_sample_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (config_done_q),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StStartup;
            cnt_q          <= '0;
            txn_q          <= TXN_FILTER;
            bi_q           <= '0;
            tx_data_q      <= '0;
            shadow_q       <= '{default: 8'h00};
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            sample_valid_q <= 1'b0;
            config_done_q  <= 1'b0;
            overrun_q      <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            txn_q          <= txn_d;
            bi_q           <= bi_d;
            tx_data_q      <= tx_data_d;
            shadow_q       <= shadow_d;
            x_q            <= x_d;
            y_q            <= y_d;
            z_q            <= z_d;
            sample_valid_q <= sample_valid_d;
            config_done_q  <= config_done_d;
            overrun_q      <= overrun_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        txn_d          = txn_q;
        bi_d           = bi_q;
        tx_data_d      = tx_data_q;
        shadow_d       = shadow_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        sample_valid_d = 1'b0;
        config_done_d  = config_done_q;
        unique case (state_q)
            StStartup: begin
                if (cnt_q == CntW'(STARTUP_DELAY - 1)) begin
                    cnt_d   = '0;
                    txn_d   = TXN_FILTER;
                    bi_d    = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoad: begin
                tx_data_d = txn_byte(txn_q, bi_q, FILTER_CTL_VAL, POWER_CTL_VAL);
                state_d   = StIssue;
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StArm;
            end
            StArm: begin
                if (spi_active) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (!spi_active) begin
                    if (txn_q == TXN_READ && bi_q >= 3'd2) shadow_d[bi_q - 3'd2] = spi_rx_data;
                    state_d = StNext;
                end else if (cnt_q == CntW'(BYTE_TIMEOUT - 1)) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StNext: begin
                if (bi_q == last_bi(txn_q)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    bi_d    = bi_q + 3'd1;
                    state_d = StLoad;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(1)) begin
                    cnt_d = '0;
                    bi_d  = '0;
                    if (txn_q == TXN_FILTER) begin
                        txn_d   = TXN_POWER;
                        state_d = StLoad;
                    end else if (txn_q == TXN_POWER) begin
                        config_done_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        // Publish all three axes on one edge so consumers never see a mix.
                        x_d            = {shadow_q[1], shadow_q[0]};
                        y_d            = {shadow_q[3], shadow_q[2]};
                        z_d            = {shadow_q[5], shadow_q[4]};
                        sample_valid_d = 1'b1;
                        state_d        = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (tick && enable) begin
                    txn_d   = TXN_READ;
                    bi_d    = '0;
                    state_d = StLoad;
                end
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
        error_d   = error_q || (state_d == StError);
        overrun_d = tick && (state_q != StIdle);
    end

    always_comb begin
        spi_start = 1'b0;
        spi_cs_n  = 1'b1;
        unique case (state_q)
            StLoad, StArm, StWait, StNext: spi_cs_n = 1'b0;
            StIssue: begin
                spi_cs_n  = 1'b0;
                spi_start = 1'b1;
            end
            default: spi_cs_n = 1'b1;
        endcase
    end

    assign spi_tx_data  = tx_data_q;
    assign x_data       = x_q;
    assign y_data       = y_q;
    assign z_data       = z_q;
    assign sample_valid = sample_valid_q;
    assign config_done  = config_done_q;
    assign overrun      = overrun_q;
    assign error        = error_q;

endmodule

// File: tb/tb_acl2_sample_sequencer.sv
// Bench for acl2_sample_sequencer: SPI master + ADXL362 register model, directed steps, random data.
module tb_acl2_sample_sequencer;

    localparam int unsigned STARTUP_DELAY = 100;
    localparam int unsigned SAMPLE_PERIOD = 1000;
    localparam int unsigned ACK_TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  spi_tx_data, spi_rx_data;
    logic        spi_start, spi_cs_n, spi_active;
    logic [15:0] x_data, y_data, z_data;
    logic        sample_valid, config_done, overrun, error;

    always #5 clk = ~clk;

    acl2_sample_sequencer #(
        .STARTUP_DELAY  (STARTUP_DELAY),
        .SAMPLE_PERIOD  (SAMPLE_PERIOD),
        .FILTER_CTL_VAL (8'h13),
        .POWER_CTL_VAL  (8'h02),
        .ACK_TIMEOUT    (ACK_TIMEOUT),
        .BYTE_TIMEOUT   (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .spi_tx_data  (spi_tx_data),
        .spi_start    (spi_start),
        .spi_cs_n     (spi_cs_n),
        .spi_rx_data  (spi_rx_data),
        .spi_active   (spi_active),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
        .sample_valid (sample_valid),
        .config_done  (config_done),
        .overrun      (overrun),
        .error        (error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Device model state: register image behind XDATA_L..ZDATA_H, SPI byte timing.
    int          byte_time = 8;
    bit          mute = 1'b0;
    logic [7:0]  regs [6];
    int          busy_cnt = 0;
    int          frame_pos = 0;
    int          cycle = 0, start_count = 0, overrun_count = 0, viol_count = 0;
    int          hi_run = 0, min_gap = 1000;
    logic        cs_prev = 1'b1;
    logic [63:0] cur_frame = '0;
    int          cur_len = 0;
    logic [63:0] frame_data [$];
    int          frame_len [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            spi_active  <= 1'b0;
            busy_cnt    <= 0;
            spi_rx_data <= 8'h00;
        end else if (spi_active) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) spi_active <= 1'b0;
        end else if (spi_start && !mute) begin
            spi_active  <= 1'b1;
            busy_cnt    <= byte_time;
            spi_rx_data <= (frame_pos >= 2) ? regs[frame_pos-2] : 8'h00;
        end
    end

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        cs_prev <= spi_cs_n;
        if (rst) begin
            if (overrun) overrun_count <= overrun_count + 1;
            if (spi_active && (spi_cs_n != cs_prev)) viol_count <= viol_count + 1;
            if (spi_start) begin
                start_count <= start_count + 1;
                cur_frame   <= {cur_frame[55:0], spi_tx_data};
                cur_len     <= cur_len + 1;
                frame_pos   <= frame_pos + 1;
                if (spi_active) viol_count <= viol_count + 1;
            end
            if (spi_cs_n) hi_run <= hi_run + 1;
            if (!cs_prev && spi_cs_n) begin
                frame_data.push_back(cur_frame);
                frame_len.push_back(cur_len);
                cur_frame <= '0;
                cur_len   <= 0;
                frame_pos <= 0;
            end
            if (cs_prev && !spi_cs_n) begin
                if (frame_len.size() > 0 && hi_run < min_gap) min_gap <= hi_run;
                hi_run <= 0;
            end
        end else begin
            cur_frame <= '0;
            cur_len   <= 0;
            frame_pos <= 0;
            hi_run    <= 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sample(input string tag);
        check({tag, "_x"}, 64'(x_data), 64'({regs[1], regs[0]}));
        check({tag, "_y"}, 64'(y_data), 64'({regs[3], regs[2]}));
        check({tag, "_z"}, 64'(z_data), 64'({regs[5], regs[4]}));
    endtask

    task automatic wait_sv(input int bound, input string tag);
        int i = 0;
        while (sample_valid !== 1'b1 && i < bound) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_valid"}, 64'(sample_valid), 64'd1);
    endtask

    task automatic wait_cfg(input string tag);
        int i = 0;
        while (config_done !== 1'b1 && i < 600) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 64'(config_done), 64'd1);
        check({tag, "_cs_high"}, 64'(spi_cs_n), 64'd1);
        check({tag, "_nframes"}, 64'(frame_data.size()), 64'd2);
        check({tag, "_frame0"}, frame_data[0], 64'h0A2C13);
        check({tag, "_len0"}, 64'(frame_len[0]), 64'd3);
        check({tag, "_frame1"}, frame_data[1], 64'h0A2D02);
        check({tag, "_len1"}, 64'(frame_len[1]), 64'd3);
        check({tag, "_gap"}, 64'(min_gap >= 2), 64'd1);
    endtask

    task automatic randomize_regs();
        for (int j = 0; j < 6; j++) regs[j] = 8'($urandom);
    endtask

    int i, sc, t_prev;

    initial begin
        for (int j = 0; j < 6; j++) regs[j] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("rst_start", 64'(spi_start), 64'd0);
        check("rst_tx", 64'(spi_tx_data), 64'd0);
        check("rst_xyz", 64'({x_data, y_data, z_data}), 64'd0);
        check("rst_flags", 64'({sample_valid, config_done, overrun, error}), 64'd0);

        // Configuration after the power-up delay.
        rst = 1'b1;
        i = 0;
        while (spi_cs_n && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("startup_delay", 64'(i >= STARTUP_DELAY && i <= STARTUP_DELAY + 1), 64'd1);
        wait_cfg("cfg");
        frame_data.delete();
        frame_len.delete();

        // Fixed burst, then randomized bursts spaced by the sample period.
        regs = '{8'h34, 8'h12, 8'hCD, 8'hFB, 8'h00, 8'h04};
        enable = 1'b1;
        wait_sv(2500, "burst0");
        check("burst0_x", 64'(x_data), 64'h1234);
        check("burst0_y", 64'(y_data), 64'hFBCD);
        check("burst0_z", 64'(z_data), 64'h0400);
        check("rd_frame", frame_data[0], 64'h0B0E000000000000);
        check("rd_len", 64'(frame_len[0]), 64'd8);
        t_prev = cycle;
        @(negedge clk);
        check("sv_pulse", 64'(sample_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            randomize_regs();
            wait_sv(2500, "burst_rand");
            check_sample("burst_rand");
            check("period", 64'(cycle - t_prev), 64'(SAMPLE_PERIOD));
            t_prev = cycle;
            @(negedge clk);
        end
        check("no_overrun", 64'(overrun_count), 64'd0);

        // Slow SPI bytes: the burst outlasts a period.
        byte_time = 130;
        randomize_regs();
        wait_sv(4000, "slow");
        check_sample("slow");
        check("overrun_seen", 64'(overrun_count > 0), 64'd1);
        byte_time = 8;
        @(negedge clk);
        randomize_regs();
        wait_sv(2500, "after_slow");
        check_sample("after_slow");
        @(negedge clk);

        // Enable dropped mid-burst.
        randomize_regs();
        i = 0;
        while (!(frame_pos == 3 && !spi_cs_n) && i < 2500) begin
            @(negedge clk);
            i++;
        end
        check("reach_byte3", 64'(frame_pos), 64'd3);
        enable = 1'b0;
        wait_sv(600, "drop");
        check_sample("drop");
        sc = start_count;
        repeat (2500) @(negedge clk);
        check("disabled_no_start", 64'(start_count - sc), 64'd0);

        // Asynchronous reset mid-burst.
        enable = 1'b1;
        randomize_regs();
        i = 0;
        while (!(frame_pos == 5 && spi_active) && i < 2500) begin
            @(negedge clk);
            i++;
        end
        check("reach_byte5", 64'(frame_pos), 64'd5);
        #2 rst = 1'b0;
        #1;
        check("async_cs_n", 64'(spi_cs_n), 64'd1);
        check("async_start", 64'(spi_start), 64'd0);
        check("async_xyz", 64'({x_data, y_data, z_data}), 64'd0);
        @(negedge clk);
        frame_data.delete();
        frame_len.delete();
        min_gap = 1000;
        @(negedge clk);
        rst = 1'b1;
        wait_cfg("recfg");
        check("recfg_xyz_zero", 64'({x_data, y_data, z_data}), 64'd0);
        wait_sv(2500, "post_rst");
        check_sample("post_rst");

        // Unresponsive SPI master: handshake timeout.
        rst = 1'b0;
        mute = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        i = 0;
        while (spi_start !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("mute_start", 64'(spi_start), 64'd1);
        i = 0;
        while (error !== 1'b1 && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("ack_timeout", 64'(i >= ACK_TIMEOUT && i <= ACK_TIMEOUT + 2), 64'd1);
        check("err_cs_n", 64'(spi_cs_n), 64'd1);
        sc = start_count;
        repeat (300) @(negedge clk);
        check("err_no_start", 64'(start_count - sc), 64'd0);
        check("err_sticky", 64'(error), 64'd1);
        check("handshake_rules", 64'(viol_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
